// File: rtl/video_pkg.sv
// Shared types and defaults for the video capture path.
// Frame buffer is 32K x 2-bit, addressed {y[7:1], x[8:1]}.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FS,
    CAPTURE,
    DONE
  } state_t;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 2;

  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;

  localparam int TH1_DEF = 47;
  localparam int TH2_DEF = 94;
  localparam int TH3_DEF = 141;

endpackage

// File: rtl/rgb_to_index.sv
// RGB565 to 2-bit colour index.
// lum = 2R + G + 2B, then a three-threshold compare.
module rgb_to_index
  import video_pkg::*;
#(
  parameter int TH1 = TH1_DEF,
  parameter int TH2 = TH2_DEF,
  parameter int TH3 = TH3_DEF
) (
  input  logic [4:0]           r,
  input  logic [5:0]           g,
  input  logic [4:0]           b,
  output logic [FB_DATA_W-1:0] idx
);

  localparam logic [7:0] T1 = 8'(TH1);
  localparam logic [7:0] T2 = 8'(TH2);
  localparam logic [7:0] T3 = 8'(TH3);

  logic [7:0] lum;

  assign lum = {2'b0, r, 1'b0}
             + {2'b0, g}
             + {2'b0, b, 1'b0};

  always_comb begin
    idx = '0;
    unique case (1'b1)
      (lum < T1):               idx = 2'd0;
      (lum >= T1 && lum < T2):  idx = 2'd1;
      (lum >= T2 && lum < T3):  idx = 2'd2;
      (lum >= T3):              idx = 2'd3;
      default:                  idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/video_capture.sv
// Captures one armed frame of an RGB565 LCD stream,
// decimated 2x2 and quantised, into the frame buffer.
module video_capture
  import video_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int TH1             = TH1_DEF,
  parameter int TH2             = TH2_DEF,
  parameter int TH3             = TH3_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  input  logic                 i_de,
  input  logic [4:0]           i_r,
  input  logic [5:0]           i_g,
  input  logic [4:0]           i_b,
  input  logic                 i_arm,
  output logic                 o_we,
  output logic [FB_ADDR_W-1:0] o_waddr,
  output logic [FB_DATA_W-1:0] o_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam logic [8:0] H_LEN = 9'(H_ACTIVE);
  localparam logic [8:0] V_LEN = 9'(V_ACTIVE);

  state_t state, state_n;

  logic       hs_q, vs_q, de_q;
  logic       vs_p, de_p;
  logic [4:0] r_q;
  logic [5:0] g_q;
  logic [4:0] b_q;
  logic [8:0] x, y;
  logic       fs, de_fall, keep;
  logic       unused_hs;
  logic [FB_DATA_W-1:0] idx;

  // Stage 0: register the stream with syncs normalised to active-high
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      vs_p <= 1'b0;
      de_p <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= i_hsync ^ SYNC_ACTIVE_LOW;
      vs_q <= i_vsync ^ SYNC_ACTIVE_LOW;
      de_q <= i_de;
      vs_p <= vs_q;
      de_p <= de_q;
      r_q  <= i_r;
      g_q  <= i_g;
      b_q  <= i_b;
    end
  end

  assign unused_hs = hs_q;
  assign fs        = vs_q & ~vs_p;
  assign de_fall   = de_p & ~de_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (i_arm) state_n = WAIT_FS;
      WAIT_FS: if (fs)    state_n = CAPTURE;
      CAPTURE: if (fs)    state_n = DONE;
      DONE:               state_n = IDLE;
      default:            state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  assign o_busy = (state == WAIT_FS) || (state == CAPTURE);
  assign o_done = (state == DONE);

  // x is the column of the pixel in stage 0; at DE fall it holds the line length
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x <= '0;
      y <= '0;
    end else if (state == WAIT_FS && fs) begin
      x <= '0;
      y <= '0;
    end else begin
      if (de_fall)
        x <= '0;
      else if (de_q && x != 9'd511)
        x <= x + 9'd1;
      if (de_fall && y != 9'd511)
        y <= y + 9'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (state == WAIT_FS && fs) begin
      o_err <= 1'b0;
    end else if (state == CAPTURE) begin
      if (de_fall && x != H_LEN) o_err <= 1'b1;
      if (fs && y != V_LEN)      o_err <= 1'b1;
    end
  end

  rgb_to_index #(
    .TH1 (TH1),
    .TH2 (TH2),
    .TH3 (TH3)
  ) u_idx (
    .r   (r_q),
    .g   (g_q),
    .b   (b_q),
    .idx (idx)
  );

  assign keep = (state == CAPTURE) && de_q && !fs
             && !x[0] && !y[0] && !y[8];

  // Stage 1: write port, address/data hold between writes
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_we <= keep;
      if (keep) begin
        o_waddr <= {y[7:1], x[8:1]};
        o_wdata <= idx;
      end
    end
  end

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a reduced 8x260 geometry.
// Two instances run in lockstep: active-low and active-high syncs.
module tb_video_capture;

  localparam int H = 8;
  localparam int V = 260;

  logic        clk;
  logic        rst_n;
  logic        vs, hs, de, arm;
  logic [4:0]  r, b;
  logic [5:0]  g;

  logic        we1, busy1, done1, err1;
  logic [14:0] waddr1;
  logic [1:0]  wdata1;
  logic        we2, busy2, done2, err2;
  logic [14:0] waddr2;
  logic [1:0]  wdata2;

  int n_chk, n_pass;
  int wcnt1, wcnt2, done_cnt, arm_line;
  int first1, last1, first2, last2;
  logic [1:0] mem1 [0:32767];
  int hits1 [0:32767];
  int hits2 [0:32767];

  video_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_hsync(~hs), .i_vsync(~vs), .i_de(de),
    .i_r(r), .i_g(g), .i_b(b), .i_arm(arm),
    .o_we(we1), .o_waddr(waddr1), .o_wdata(wdata1),
    .o_busy(busy1), .o_done(done1), .o_err(err1)
  );

  video_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b0)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .i_r(r), .i_g(g), .i_b(b), .i_arm(arm),
    .o_we(we2), .o_waddr(waddr2), .o_wdata(wdata2),
    .o_busy(busy2), .o_done(done2), .o_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int pat, input int xx,
                                      input int yy);
    logic [15:0] p;
    p = {5'd31, 6'd63, 5'd31};
    if (pat == 1 && xx == 2 && yy == 4) p = {5'd10, 6'd0, 5'd0};
    if (pat == 2 && yy == 0) begin
      if (xx == 0) p = {5'd0, 6'd46, 5'd0};
      if (xx == 2) p = {5'd0, 6'd47, 5'd0};
      if (xx == 4) p = {5'd15, 6'd63, 5'd0};
      if (xx == 6) p = {5'd15, 6'd62, 5'd1};
    end
    if (pat == 2 && yy == 2) begin
      if (xx == 0) p = {5'd31, 6'd62, 5'd8};
      if (xx == 2) p = {5'd31, 6'd63, 5'd8};
    end
    return p;
  endfunction

  // Every cycle passes through here: sample outputs at negedge
  task automatic tick();
    @(negedge clk);
    if (we1) begin
      if (wcnt1 == 0) first1 = int'(waddr1);
      last1 = int'(waddr1);
      wcnt1++;
      mem1[waddr1] = wdata1;
      hits1[waddr1]++;
    end
    if (we2) begin
      if (wcnt2 == 0) first2 = int'(waddr2);
      last2 = int'(waddr2);
      wcnt2++;
      hits2[waddr2]++;
    end
    if (done1) done_cnt++;
  endtask

  task automatic drive(input logic v, input logic h, input logic d,
                       input logic [15:0] p);
    tick();
    arm = 1'b0;
    vs = v; hs = h; de = d;
    {r, g, b} = p;
  endtask

  task automatic clr();
    wcnt1 = 0; wcnt2 = 0; done_cnt = 0;
    first1 = -1; last1 = -1; first2 = -1; last2 = -1;
    for (int a = 0; a < 32768; a++) begin
      mem1[a] = 2'd0; hits1[a] = 0; hits2[a] = 0;
    end
  endtask

  task automatic arm_pulse();
    tick();
    arm = 1'b1;
  endtask

  task automatic vs_pulse();
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic line(input int yy, input int n, input int pat);
    drive(1'b0, 1'b1, 1'b0, '0);
    if (yy == arm_line) arm = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int xx = 0; xx < n; xx++)
      drive(1'b0, 1'b0, 1'b1, pix(pat, xx, yy));
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic frame(input int nl, input int sl, input int pat);
    vs_pulse();
    for (int yy = 0; yy < nl; yy++)
      line(yy, (yy == sl) ? H - 1 : H, pat);
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic capture(input int nl, input int sl, input int pat);
    clr();
    arm_pulse();
    frame(nl, sl, pat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    n_chk++;
    if ({we1, busy1, done1, err1} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {we1, busy1, done1, err1});
    else n_pass++;
    n_chk++;
    if (waddr1 !== 15'd0)
      $display("FAIL reset_waddr got %h want 0000", waddr1);
    else n_pass++;
    n_chk++;
    if (wdata1 !== 2'd0)
      $display("FAIL reset_wdata got %0d want 0", wdata1);
    else n_pass++;
    n_chk++;
    if ({we2, busy2, done2, err2} !== 4'b0)
      $display("FAIL reset_flags2 got %b want 0000", {we2, busy2, done2, err2});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_full();
    int ok, diff;
    clr();
    arm_pulse();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_chk++;
    if (busy1 !== 1'b1) $display("FAIL busy_after_arm got %b want 1", busy1);
    else n_pass++;
    frame(V, -1, 0);
    n_chk++;
    if (wcnt1 != 512) $display("FAIL full_writes got %0d want 512", wcnt1);
    else n_pass++;
    n_chk++;
    if (first1 != 0) $display("FAIL full_first got %h want 0", first1);
    else n_pass++;
    n_chk++;
    if (last1 != 32'h7F03) $display("FAIL full_last got %h want 7f03", last1);
    else n_pass++;
    ok = 0;
    for (int yy = 0; yy < 128; yy++)
      for (int xx = 0; xx < 4; xx++)
        if (hits1[(yy << 8) | xx] == 1 && mem1[(yy << 8) | xx] == 2'd3) ok++;
    n_chk++;
    if (ok != 512) $display("FAIL full_cells got %0d want 512", ok);
    else n_pass++;
    n_chk++;
    if (done_cnt != 1) $display("FAIL full_done got %0d want 1", done_cnt);
    else n_pass++;
    n_chk++;
    if (err1 !== 1'b0) $display("FAIL full_err got %b want 0", err1);
    else n_pass++;
    diff = 0;
    for (int a = 0; a < 32768; a++) if (hits1[a] != hits2[a]) diff++;
    n_chk++;
    if (wcnt2 != 512 || diff != 0)
      $display("FAIL hipol_writes got %0d diff %0d want 512 diff 0", wcnt2, diff);
    else n_pass++;
    n_chk++;
    if (first2 != 0 || last2 != 32'h7F03)
      $display("FAIL hipol_ends got %h/%h want 0/7f03", first2, last2);
    else n_pass++;
  endtask

  task automatic test_gradient();
    capture(V, -1, 1);
    n_chk++;
    if (mem1[15'h0201] !== 2'd0 || hits1[15'h0201] != 1)
      $display("FAIL grad_pix got %0d x%0d want 0 x1", mem1[15'h0201], hits1[15'h0201]);
    else n_pass++;
    n_chk++;
    if (mem1[15'h0200] !== 2'd3 || mem1[15'h0301] !== 2'd3)
      $display("FAIL grad_nbr got %0d/%0d want 3/3", mem1[15'h0200], mem1[15'h0301]);
    else n_pass++;
    n_chk++;
    if (wcnt1 != 512) $display("FAIL grad_writes got %0d want 512", wcnt1);
    else n_pass++;
  endtask

  task automatic test_thresholds();
    int adr [6] = '{32'h000, 32'h001, 32'h002, 32'h003, 32'h100, 32'h101};
    logic [1:0] exp [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    capture(V, -1, 2);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (mem1[adr[i]] !== exp[i])
        $display("FAIL thresh_%0d got %0d want %0d", i, mem1[adr[i]], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_short_line();
    capture(V, 10, 0);
    n_chk++;
    if (err1 !== 1'b1 || done_cnt != 1)
      $display("FAIL short_line got err %b done %0d want 1 1", err1, done_cnt);
    else n_pass++;
    capture(V, -1, 0);
    n_chk++;
    if (err1 !== 1'b0) $display("FAIL err_clear got %b want 0", err1);
    else n_pass++;
  endtask

  task automatic test_short_frame();
    capture(V - 2, -1, 0);
    n_chk++;
    if (err1 !== 1'b1) $display("FAIL short_frame got %b want 1", err1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0;
    clr();
    arm_pulse();
    vs_pulse();
    for (int yy = 0; yy < 20; yy++) line(yy, (yy == 5) ? H - 1 : H, 0);
    n_chk++;
    if (err1 !== 1'b1) $display("FAIL mid_err_pre got %b want 1", err1);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int xx = 0; xx < 4; xx++) drive(1'b0, 1'b0, 1'b1, pix(0, xx, 20));
    rst_n = 1'b0;
    tick();
    n_chk++;
    if ({we1, busy1, err1} !== 3'b000)
      $display("FAIL mid_reset got we/busy/err %b want 000", {we1, busy1, err1});
    else n_pass++;
    w0 = wcnt1;
    rst_n = 1'b1;
    for (int xx = 4; xx < H; xx++) drive(1'b0, 1'b0, 1'b1, pix(0, xx, 20));
    drive(1'b0, 1'b0, 1'b0, '0);
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
    n_chk++;
    if (done_cnt != 0 || busy1 !== 1'b0 || wcnt1 != w0)
      $display("FAIL mid_after got done %0d busy %b writes %0d want 0 0 %0d",
               done_cnt, busy1, wcnt1, w0);
    else n_pass++;
  endtask

  task automatic test_arm_busy();
    arm_line = 30;
    capture(V, -1, 0);
    arm_line = -1;
    frame(V, -1, 0);
    n_chk++;
    if (done_cnt != 1) $display("FAIL arm_busy_done got %0d want 1", done_cnt);
    else n_pass++;
    n_chk++;
    if (wcnt1 != 512 || busy1 !== 1'b0)
      $display("FAIL arm_busy got writes %0d busy %b want 512 0", wcnt1, busy1);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; arm_line = -1;
    rst_n = 1'b0; arm = 1'b0;
    vs = 1'b0; hs = 1'b0; de = 1'b0;
    r = '0; g = '0; b = '0;
    clr();
    test_reset();
    test_full();
    test_gradient();
    test_thresholds();
    test_short_line();
    test_short_frame();
    test_reset_mid();
    test_arm_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
